// File: rtl/dram_model.sv
// dram_model: cycle-based RAS/CAS DRAM responder with a word-addressed array,
// multiplexed row/column address decode and programmable read/write latency.
// Optional protocol checker: define DRAM_PROTOCOL_CHECK_EN to drive DRAM_err;
// without it DRAM_err is tied low and no checker logic is built.
module dram_model #(
    parameter int unsigned ROWADDRWIDTH  = 11,
    parameter int unsigned COLADDRWIDTH  = 10,
    parameter int unsigned DRAMADDRWIDTH = 11,
    parameter int unsigned DATAWIDTH     = 32,
    parameter int unsigned READ_LAT      = 4,
    parameter int unsigned WRITE_LAT     = 4
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     DRAM_enable_n,
    input  logic                     DRAM_RAS_n,
    input  logic                     DRAM_CAS_n,
    input  logic                     DRAM_write_n,
    input  logic [DRAMADDRWIDTH-1:0] DRAM_addr,
    input  logic [DATAWIDTH-1:0]     DRAM_in,
    output logic [DATAWIDTH-1:0]     DRAM_out,
    output logic                     DRAM_valid,
    output logic                     DRAM_err
);

    localparam int unsigned IDXWIDTH = ROWADDRWIDTH + COLADDRWIDTH;
    localparam int unsigned DEPTH    = 1 << IDXWIDTH;
    localparam int unsigned CNTWIDTH = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ROW_OPEN = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR_WAIT  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_ras_q;
    logic                    r_cas_q;
    logic [ROWADDRWIDTH-1:0] r_row;
    logic [COLADDRWIDTH-1:0] r_col;
    logic [CNTWIDTH-1:0]     r_cnt;
    logic [CNTWIDTH-1:0]     w_cnt_nxt;
    logic [DATAWIDTH-1:0]    r_out;
    logic [DATAWIDTH-1:0]    w_out_nxt;
    logic                    r_valid;
    logic                    w_valid_nxt;
    logic                    w_row_ld;
    logic                    w_col_ld;
    logic                    w_we;
    logic                    w_ras_fall;
    logic                    w_cas_fall;
    logic                    w_strobes_low;
    logic [IDXWIDTH-1:0]     w_idx;
    logic [DATAWIDTH-1:0]    r_mem [DEPTH];

    assign w_ras_fall    = !DRAM_RAS_n && r_ras_q;
    assign w_cas_fall    = !DRAM_CAS_n && r_cas_q;
    assign w_strobes_low = !DRAM_RAS_n && !DRAM_CAS_n;
    assign w_idx         = {r_row, r_col};

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode; deselect and RAS release take priority over CAS
    always_comb begin
        w_state_nxt = r_state;
        if (DRAM_enable_n) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_ras_fall) w_state_nxt = S_ROW_OPEN;
                S_ROW_OPEN: begin
                    if (DRAM_RAS_n)      w_state_nxt = S_IDLE;
                    else if (w_cas_fall) w_state_nxt = DRAM_write_n ? S_RD_WAIT : S_WR_WAIT;
                end
                S_RD_WAIT: begin
                    if (DRAM_RAS_n)                            w_state_nxt = S_IDLE;
                    else if (DRAM_CAS_n)                       w_state_nxt = S_ROW_OPEN;
                    else if (r_cnt == CNTWIDTH'(READ_LAT))     w_state_nxt = S_DONE;
                end
                S_WR_WAIT: begin
                    if (DRAM_RAS_n)                            w_state_nxt = S_IDLE;
                    else if (DRAM_CAS_n)                       w_state_nxt = S_ROW_OPEN;
                    else if (r_cnt == CNTWIDTH'(WRITE_LAT))    w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (DRAM_RAS_n)      w_state_nxt = S_IDLE;
                    else if (DRAM_CAS_n) w_state_nxt = S_ROW_OPEN;
                end
                default:                 w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output/datapath decode: next read data, latency counter, latches, array write
    always_comb begin
        w_out_nxt   = r_out;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        w_row_ld    = 1'b0;
        w_col_ld    = 1'b0;
        w_we        = 1'b0;
        if (DRAM_enable_n) begin
            w_out_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE:     w_row_ld = w_ras_fall;
                S_ROW_OPEN: begin
                    if (!DRAM_RAS_n && w_cas_fall) begin
                        w_col_ld  = 1'b1;
                        w_cnt_nxt = CNTWIDTH'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (w_strobes_low) begin
                        if (r_cnt == CNTWIDTH'(READ_LAT)) begin
                            w_out_nxt   = r_mem[w_idx];
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNTWIDTH'(1);
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (w_strobes_low) begin
                        if (r_cnt == CNTWIDTH'(WRITE_LAT)) w_we = 1'b1;
                        else                               w_cnt_nxt = r_cnt + CNTWIDTH'(1);
                    end
                end
                S_DONE: begin
                    if (DRAM_RAS_n || DRAM_CAS_n) begin
                        w_out_nxt   = '0;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_out_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers: strobe history, address latches, counter, read data
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_ras_q <= 1'b1;
            r_cas_q <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ras_q <= DRAM_RAS_n;
            r_cas_q <= DRAM_CAS_n;
            if (w_row_ld) r_row <= DRAM_addr[ROWADDRWIDTH-1:0];
            if (w_col_ld) r_col <= DRAM_addr[COLADDRWIDTH-1:0];
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Storage array; contents survive reset, but a reset edge blocks the commit
    always_ff @(posedge HCLK) begin
        if (HRESETn && w_we) r_mem[w_idx] <= DRAM_in;
    end

    assign DRAM_out   = r_out;
    assign DRAM_valid = r_valid;

`ifdef DRAM_PROTOCOL_CHECK_EN
    logic [DRAMADDRWIDTH-1:0] r_addr_q;
    logic                     r_write_q;
    logic                     r_err;
    logic                     w_err_set;

    // Previous-cycle copies of address and direction for change detection
    always_ff @(posedge HCLK) begin
        r_addr_q  <= DRAM_addr;
        r_write_q <= DRAM_write_n;
    end

    // Protocol violation detect
    always_comb begin
        w_err_set = 1'b0;
        if (w_cas_fall && (r_state != S_ROW_OPEN))                 w_err_set = 1'b1;
        if (w_ras_fall && !DRAM_CAS_n)                              w_err_set = 1'b1;
        if (((r_state == S_RD_WAIT) || (r_state == S_WR_WAIT) || (r_state == S_DONE))
            && (DRAM_write_n != r_write_q))                         w_err_set = 1'b1;
        if ((w_ras_fall || w_cas_fall) && (DRAM_addr != r_addr_q))  w_err_set = 1'b1;
    end

    // Sticky error flag
    always_ff @(posedge HCLK) begin
        if (!HRESETn)       r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
    end

`ifndef SYNTHESIS
    // Report the first violation since reset
    always_ff @(posedge HCLK) begin
        if (HRESETn && w_err_set && !r_err) $error("dram_model: DRAM pin protocol violation");
    end
`endif

    assign DRAM_err = r_err;
`else
    assign DRAM_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_model.sv
// tb_dram_model: directed bench for dram_model with a transaction-level model
// (word array + read-latency window) checked every cycle on the falling edge.
module tb_dram_model;

    localparam int unsigned RW = 11;
    localparam int unsigned CW = 10;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;
    localparam int          RL = 4;
    localparam int          WL = 4;
`ifdef DRAM_PROTOCOL_CHECK_EN
    localparam logic [31:0] ERR_LIT = 32'd1;
`else
    localparam logic [31:0] ERR_LIT = 32'd0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          DRAM_enable_n;
    logic          DRAM_RAS_n;
    logic          DRAM_CAS_n;
    logic          DRAM_write_n;
    logic [AW-1:0] DRAM_addr;
    logic [DW-1:0] DRAM_in;
    logic [DW-1:0] DRAM_out;
    logic          DRAM_valid;
    logic          DRAM_err;

    dram_model #(
        .ROWADDRWIDTH (RW),
        .COLADDRWIDTH (CW),
        .DRAMADDRWIDTH(AW),
        .DATAWIDTH    (DW),
        .READ_LAT     (RL),
        .WRITE_LAT    (WL)
    ) u_dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .DRAM_enable_n(DRAM_enable_n),
        .DRAM_RAS_n   (DRAM_RAS_n),
        .DRAM_CAS_n   (DRAM_CAS_n),
        .DRAM_write_n (DRAM_write_n),
        .DRAM_addr    (DRAM_addr),
        .DRAM_in      (DRAM_in),
        .DRAM_out     (DRAM_out),
        .DRAM_valid   (DRAM_valid),
        .DRAM_err     (DRAM_err)
    );

    always #5 HCLK = ~HCLK;

    int            cyc    = 0;
    int            n_chk  = 0;
    int            n_pass = 0;
    logic          chk_on = 1'b0;
    logic          rd_on  = 1'b0;
    int            rd_t0  = 0;
    logic [31:0]   rd_exp = '0;
    logic          exp_err = 1'b0;
    logic [RW-1:0] cur_row = '0;
    logic [31:0]   model_mem [int];

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int key(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return int'({r, c});
    endfunction

    // Model: read data is visible from the READ_LAT-th edge after the CAS-fall sample
    // until the access is released; otherwise DRAM_out is zero.
    always @(negedge HCLK) begin : cmp
        logic        ev;
        logic [31:0] eo;
        if (chk_on) begin
            ev = rd_on && ((cyc - rd_t0) >= RL);
            eo = ev ? rd_exp : 32'd0;
            check("cyc_valid", {31'd0, DRAM_valid}, {31'd0, ev});
            check("cyc_out",   DRAM_out, eo);
            check("cyc_err",   {31'd0, DRAM_err}, {31'd0, exp_err});
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic open_row(input logic [RW-1:0] row);
        DRAM_addr  = AW'(row);
        DRAM_RAS_n = 1'b1;
        step();
        DRAM_RAS_n = 1'b0;
        step();
        cur_row = row;
    endtask

    task automatic close_row();
        DRAM_RAS_n = 1'b1;
        step();
    endtask

    task automatic col_write(input logic [CW-1:0] col, input logic [31:0] data, input int hold);
        DRAM_addr = AW'(col);
        step();
        DRAM_write_n = 1'b0;
        DRAM_in      = data;
        DRAM_CAS_n   = 1'b0;
        step();
        repeat (hold) step();
        DRAM_CAS_n = 1'b1;
        step();
        DRAM_write_n = 1'b1;
        if (hold >= WL) model_mem[key(cur_row, col)] = data;
    endtask

    task automatic col_read(input logic [CW-1:0] col, input logic [31:0] lit);
        DRAM_addr = AW'(col);
        step();
        DRAM_CAS_n = 1'b0;
        step();
        rd_exp = model_mem.exists(key(cur_row, col)) ? model_mem[key(cur_row, col)] : 32'd0;
        rd_t0  = cyc;
        rd_on  = 1'b1;
        for (int k = 1; k <= RL + 2; k++) begin
            step();
            if (k == RL - 1) check("rd_pre_lat_valid", {31'd0, DRAM_valid}, 32'd0);
            if (k == RL) begin
                check("rd_lat_valid", {31'd0, DRAM_valid}, 32'd1);
                check("rd_lat_data", DRAM_out, lit);
            end
            if (k == RL + 2) check("rd_hold_data", DRAM_out, lit);
        end
        DRAM_CAS_n = 1'b1;
        step();
        rd_on = 1'b0;
        check("rd_release_valid", {31'd0, DRAM_valid}, 32'd0);
        check("rd_release_out", DRAM_out, 32'd0);
    endtask

    logic [31:0] ahb_addr [2];
    logic [31:0] ahb_data [2];
    logic [31:0] word;

    initial begin
        HRESETn       = 1'b0;
        DRAM_enable_n = 1'b0;
        DRAM_RAS_n    = 1'b1;
        DRAM_CAS_n    = 1'b1;
        DRAM_write_n  = 1'b1;
        DRAM_addr     = '0;
        DRAM_in       = '0;
        ahb_addr      = '{32'h2000_0100, 32'h2000_0104};
        ahb_data      = '{32'hCAFE_F00D, 32'h0BAD_C0DE};

        // Reset state
        step();
        chk_on = 1'b1;
        step();
        check("reset_out",   DRAM_out, 32'd0);
        check("reset_valid", {31'd0, DRAM_valid}, 32'd0);
        check("reset_err",   {31'd0, DRAM_err}, 32'd0);
        HRESETn = 1'b1;
        step();

        // Write then read, separate row opens
        open_row(11'h012);
        col_write(10'h034, 32'hDEAD_BEEF, WL);
        close_row();
        open_row(11'h012);
        col_read(10'h034, 32'hDEAD_BEEF);
        close_row();

        // Page mode on the top row, extreme columns
        open_row(11'h7FF);
        col_write(10'h000, 32'h1111_1111, WL);
        col_write(10'h3FF, 32'h2222_2222, WL + 1);
        col_read(10'h000, 32'h1111_1111);
        col_read(10'h3FF, 32'h2222_2222);
        close_row();

        // Aborted write leaves old contents; row stays open for the read
        open_row(11'h155);
        col_write(10'h0AA, 32'h600D_F00D, WL);
        col_write(10'h0AA, 32'hA5A5_A5A5, 2);
        col_read(10'h0AA, 32'h600D_F00D);
        close_row();

        // Reset during RD_WAIT
        open_row(11'h012);
        DRAM_addr = AW'(10'h034);
        step();
        DRAM_CAS_n = 1'b0;
        step();
        step();
        step();
        HRESETn = 1'b0;
        step();
        check("rst_mid_out",   DRAM_out, 32'd0);
        check("rst_mid_valid", {31'd0, DRAM_valid}, 32'd0);
        HRESETn    = 1'b1;
        DRAM_RAS_n = 1'b1;
        DRAM_CAS_n = 1'b1;
        step();
        open_row(11'h012);
        col_read(10'h034, 32'hDEAD_BEEF);
        close_row();

        // Wrapper-style word addresses (AHB byte address / 4)
        for (int i = 0; i < 2; i++) begin
            word = ahb_addr[i] >> 2;
            open_row(RW'(word[20:10]));
            col_write(CW'(word[9:0]), ahb_data[i], WL);
            close_row();
        end
        for (int i = 0; i < 2; i++) begin
            word = ahb_addr[i] >> 2;
            open_row(RW'(word[20:10]));
            col_read(CW'(word[9:0]), ahb_data[i]);
            close_row();
        end

        // Chip deselect while read data is held
        open_row(11'h012);
        DRAM_addr = AW'(10'h034);
        step();
        DRAM_CAS_n = 1'b0;
        step();
        rd_exp = model_mem[key(cur_row, 10'h034)];
        rd_t0  = cyc;
        rd_on  = 1'b1;
        repeat (RL + 1) step();
        check("desel_pre_valid", {31'd0, DRAM_valid}, 32'd1);
        DRAM_enable_n = 1'b1;
        step();
        rd_on = 1'b0;
        check("desel_out",   DRAM_out, 32'd0);
        check("desel_valid", {31'd0, DRAM_valid}, 32'd0);
        DRAM_enable_n = 1'b0;
        DRAM_RAS_n    = 1'b1;
        DRAM_CAS_n    = 1'b1;
        step();

        // CAS fall with RAS high: flagged only when the checker is built
        DRAM_CAS_n = 1'b0;
        step();
        exp_err = ERR_LIT[0];
        check("proto_err_set", {31'd0, DRAM_err}, ERR_LIT);
        DRAM_CAS_n = 1'b1;
        step();
        step();
        check("proto_err_sticky", {31'd0, DRAM_err}, ERR_LIT);
        HRESETn = 1'b0;
        step();
        exp_err = 1'b0;
        check("proto_err_reset", {31'd0, DRAM_err}, 32'd0);
        HRESETn = 1'b1;
        step();
        step();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dram_model.md
Name: dram_model

Overview:
- Synthesizable cycle-based DRAM device model. It is the responder end of the RAS/CAS DRAM pin interface that the AHB-side DRAM wrapper drives.
- Decodes the multiplexed row/column address, counts programmable read and write latencies, and holds a word-addressed storage array.
- Instantiated in the top-level testbench and in the FPGA build beside the DRAM wrapper, with pins connected one-to-one.

Parameters:
- ROWADDRWIDTH, 11, row address bits taken from DRAM_addr at RAS fall
- COLADDRWIDTH, 10, column address bits taken from DRAM_addr[COLADDRWIDTH-1:0] at CAS fall
- DRAMADDRWIDTH, 11, width of the DRAM_addr pin; must be >= ROWADDRWIDTH and >= COLADDRWIDTH
- DATAWIDTH, 32, word width
- READ_LAT, 4, cycles from CAS-fall sample to DRAM_out valid; range 1..15
- WRITE_LAT, 4, cycles from CAS-fall sample to array commit; range 1..15

Ports:
- HCLK  in  1  clock; all logic on the rising edge
- HRESETn  in  1  reset, synchronous, active-low
- DRAM_enable_n  in  1  chip select, active-low
- DRAM_RAS_n  in  1  row strobe, active-low
- DRAM_CAS_n  in  1  column strobe, active-low
- DRAM_write_n  in  1  0 = write access; sampled at CAS fall
- DRAM_addr  in  DRAMADDRWIDTH  multiplexed row/column address
- DRAM_in  in  DATAWIDTH  write data
- DRAM_out  out  DATAWIDTH  read data, registered
- DRAM_valid  out  1  DRAM_out carries valid read data (debug/monitor)
- DRAM_err  out  1  sticky protocol-error flag (see Optional Feature)

Behaviour:
- Edge detection: registered ras_q/cas_q. RAS fall = RAS_n==0 && ras_q==1. CAS fall is defined likewise. Both registers reset to 1.
- Reset: state=IDLE, counter=0, DRAM_out=0, DRAM_valid=0, DRAM_err=0, ras_q=cas_q=1. The array is not cleared, and a reset mid-access aborts it with no commit.
- Chip deselect: DRAM_enable_n==1 in any state → IDLE next cycle, DRAM_out=0, DRAM_valid=0, pending write dropped.
- State IDLE:
  - RAS fall with enable_n==0 → ROW_OPEN.
  - Latch row = DRAM_addr[ROWADDRWIDTH-1:0].
- State ROW_OPEN:
  - CAS fall → RD_WAIT if DRAM_write_n==1, else WR_WAIT.
  - Latch col = DRAM_addr[COLADDRWIDTH-1:0]. Counter loads 1.
  - RAS_n==1 → IDLE.
- State RD_WAIT:
  - Counter increments each cycle.
  - At the edge where counter==READ_LAT, register DRAM_out=mem[{row,col}] and set DRAM_valid=1 → DONE.
  - READ_LAT=1 gives data on the edge after the CAS-fall sample.
- State WR_WAIT:
  - At the edge where counter==WRITE_LAT, write mem[{row,col}]=DRAM_in, sampling DRAM_in on that edge → DONE.
- Early strobe release in RD_WAIT or WR_WAIT:
  - CAS_n==1 → ROW_OPEN, access dropped (no commit, DRAM_out stays 0).
  - RAS_n==1 → IDLE, access dropped.
- State DONE:
  - DRAM_out and DRAM_valid hold while CAS_n==0.
  - CAS_n==1 → ROW_OPEN, clearing DRAM_out and DRAM_valid.
  - RAS_n==1 → IDLE, clearing DRAM_out and DRAM_valid.
  - If both strobes release in the same cycle, the RAS release wins: next state is IDLE.
- Page mode: while in ROW_OPEN, a new CAS fall starts a new column access on the same row.
- Back-to-back accesses: a RAS rise followed by a RAS fall 1 cycle later opens a new row; a minimum RAS-high time of 1 cycle is required.
- Address index is {row,col}, giving ROWADDRWIDTH+COLADDRWIDTH bits and 2^21 words by default. Column bits above COLADDRWIDTH are ignored.

Optional Feature:
- Macro: DRAM_PROTOCOL_CHECK_EN.
- Defined: DRAM_err is set the cycle after any of the following, and stays set until reset:
  - a CAS fall outside ROW_OPEN;
  - a RAS fall while CAS_n==0;
  - DRAM_write_n changing during RD_WAIT, WR_WAIT or DONE;
  - DRAM_addr changing during the cycle of a RAS fall or CAS fall relative to the previous cycle.
- Defined, simulation only: a $error message is also printed when the flag sets.
- Not defined: DRAM_err is tied to 0 and no checker logic is built.
- Functional behaviour is identical in both builds.

Test Plan:
- Write then read:
  - Stimulus: write 0xDEADBEEF to row 0x012, col 0x034; then read the same address.
  - Response: DRAM_out==0xDEADBEEF with DRAM_valid=1 exactly READ_LAT=4 cycles after the CAS-fall sample, holding until CAS_n rises.
- Page mode:
  - Stimulus: open row 0x7FF; write cols 0x000, 0x3FF with 0x11111111 and 0x22222222 without RAS release; then read both back.
  - Response: 0x11111111 and 0x22222222 returned; no cross-column aliasing.
- Aborted write:
  - Stimulus: start a write of 0xA5A5A5A5 and raise CAS_n after 2 cycles (before WRITE_LAT); then read the same address.
  - Response: the old contents are returned; state returns to ROW_OPEN.
- Reset mid-read:
  - Stimulus: HRESETn=0 for 1 cycle during RD_WAIT.
  - Response: DRAM_out=0, DRAM_valid=0 next cycle; a subsequent access works and previously written data is intact.
- DRAM wrapper integration:
  - Stimulus: drive the wrapper with AHB single read/write transfers to addresses 0x20000100 and 0x20000104, with matching timer latencies.
  - Response: HRDATA matches written data; DRAM_err stays 0.
- Protocol checker (DRAM_PROTOCOL_CHECK_EN defined):
  - Stimulus: CAS fall with RAS_n=1.
  - Response: DRAM_err=1 the next cycle, staying set until reset.
  - Without the macro: DRAM_err stays 0.
